// File: rtl/mux_display_pkg.sv
// -----------------------------------------------------------------------------
// mux_display_pkg
// Shared types, constants and the seven-segment glyph decoder used by the
// multiplexed display counter and its digit scanner.
//   digit_t     : one 4-bit count nibble / display digit
//   SEG_BLANK   : active-low pattern with every segment off
//   BCD_MAX     : largest decimal digit value
//   hex_to_seg  : nibble -> active-low glyph, bit6 = g ... bit0 = a
// -----------------------------------------------------------------------------
package mux_display_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam digit_t     BCD_MAX   = 4'd9;

    function automatic logic [6:0] hex_to_seg(input digit_t d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
// Time-multiplexes an N-digit value onto one active-low seven-segment display.
// A shadow copy of the count is taken only when the digit index wraps to 0, so
// a frame always shows one consistent value.
// Ports:
//   clk50M, rst : system clock, asynchronous active-high reset
//   scan        : one-cycle strobe advancing the digit index
//   count       : live counter value (4 bits per digit)
//   seg         : active-low segments, bit6 = g ... bit0 = a (registered)
//   cat         : active-low digit enables, one-hot-low (registered)
// -----------------------------------------------------------------------------
module seg_scanner
    import mux_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 17
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                scan,
    input  logic [4*DIGITS-1:0] count,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   cat
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // The strobe is produced by the top-level prescaler; this only guards the
    // period the scanner is built for.
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("seg_scanner: SCAN_DIV must be at least 1");
    end

    logic [IDX_W-1:0]         index;
    digit_t [DIGITS-1:0]      shadow;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            index  <= '0;
            shadow <= '0;
            seg    <= SEG_BLANK;
            cat    <= '1;
        end else begin
            // Outputs follow the index one clock later.
            seg <= hex_to_seg(shadow[index]);
            cat <= ~(DIGITS'(1) << index);
            if (scan) begin
                if (index == LAST_IDX) begin
                    index  <= '0;
                    shadow <= count;
                end else begin
                    index <= index + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mux_display_counter.sv
// -----------------------------------------------------------------------------
// mux_display_counter
// N-digit up/down counter with synchronous load, run/stop toggle button,
// one-cycle wrap strobe and built-in prescaler, driving a multiplexed
// active-low seven-segment display.
// Optional build macro: MUX_DISPLAY_BCD_EN -- each nibble counts 0-9 with
// ripple carry/borrow, and loaded nibbles above 9 are clamped to 9.
// Ports:
//   clk50M, rst  : system clock, asynchronous active-high reset
//   run_toggle   : asynchronous button level, each rising edge toggles running
//   dir          : 1 = count up, 0 = count down (sampled on each tick)
//   load         : synchronous load strobe, highest priority
//   load_val     : value loaded into count
//   count        : live counter value
//   running      : counter-enabled flag
//   wrap         : one-cycle pulse on roll-over / roll-under
//   seg, cat     : active-low segments and digit enables
// -----------------------------------------------------------------------------
module mux_display_counter
    import mux_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 22,
    parameter int SCAN_DIV = 17
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                run_toggle,
    input  logic                dir,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                wrap,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   cat
);

    localparam int W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("mux_display_counter: DIGITS must be 1..8");
    end
    if (TICK_DIV <= SCAN_DIV) begin : g_bad_div
        $error("mux_display_counter: TICK_DIV must exceed SCAN_DIV");
    end

    // ---------------- prescaler ----------------
    logic [TICK_DIV-1:0] presc;
    logic                tick;
    logic                scan;

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) presc <= '0;
        else     presc <= presc + TICK_DIV'(1);
    end

    assign tick = &presc;
    assign scan = &presc[SCAN_DIV-1:0];

    // ---------------- run/stop button ----------------
    // Two flops resynchronise the raw level; the third holds the previous
    // synchronised value so a held button toggles only once.
    logic sync1, sync2, sync_prev;
    logic toggle_edge;

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            running   <= 1'b0;
        end else begin
            sync1     <= run_toggle;
            sync2     <= sync1;
            sync_prev <= sync2;
            running   <= running ^ toggle_edge;
        end
    end

    assign toggle_edge = sync2 & ~sync_prev;

    // ---------------- next count value ----------------
    // step_carry is the carry (up) or borrow (down) out of the top digit,
    // which is exactly the wrap condition.
    logic [W-1:0] step_val;
    logic         step_carry;
    logic [W-1:0] load_eff;

    // NOTE: every variable is given a default first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    always_comb begin
        step_val   = count;
        step_carry = 1'b0;
        load_eff   = load_val;
`ifdef MUX_DISPLAY_BCD_EN
        step_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit_t d;
            d = count[4*i +: 4];
            if (step_carry) begin
                if (dir) begin
                    if (d >= BCD_MAX) d = '0;
                    else begin
                        d          = d + 4'd1;
                        step_carry = 1'b0;
                    end
                end else begin
                    if (d == '0) d = BCD_MAX;
                    else begin
                        d          = d - 4'd1;
                        step_carry = 1'b0;
                    end
                end
            end
            step_val[4*i +: 4] = d;
            if (load_val[4*i +: 4] > BCD_MAX) load_eff[4*i +: 4] = BCD_MAX;
        end
`else
        if (dir) {step_carry, step_val} = {1'b0, count} + (W+1)'(1);
        else     {step_carry, step_val} = {1'b0, count} - (W+1)'(1);
`endif
    end

    // running is read before its own update this edge, so a tick coinciding
    // with a toggle edge uses the pre-toggle value.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_eff;
            wrap  <= 1'b0;
        end else if (tick && running) begin
            count <= step_val;
            wrap  <= step_carry;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // ---------------- display ----------------
    seg_scanner #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk50M (clk50M),
        .rst    (rst),
        .scan   (scan),
        .count  (count),
        .seg    (seg),
        .cat    (cat)
    );

endmodule

// File: tb/tb_mux_display_counter.sv
// -----------------------------------------------------------------------------
// tb_mux_display_counter
// Directed and random stimulus for mux_display_counter (DIGITS=4, TICK_DIV=3,
// SCAN_DIV=1). A behavioural model derives every expected output from the
// clock count since reset, the sampled input history and plain arithmetic on
// the counter value. Honours MUX_DISPLAY_BCD_EN when defined.
// -----------------------------------------------------------------------------
module tb_mux_display_counter;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 3;
    localparam int SCAN_DIV = 1;
    localparam int W        = 4 * DIGITS;
    localparam int TICK_P   = 1 << TICK_DIV;
    localparam int SCAN_P   = 1 << SCAN_DIV;

    logic              clk50M     = 1'b0;
    logic              rst        = 1'b0;
    logic              run_toggle = 1'b0;
    logic              dir        = 1'b0;
    logic              load       = 1'b0;
    logic [W-1:0]      load_val   = '0;
    logic [W-1:0]      count;
    logic              running;
    logic              wrap;
    logic [6:0]        seg;
    logic [DIGITS-1:0] cat;

    always #5 clk50M = ~clk50M;

    mux_display_counter #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk50M     (clk50M),
        .rst        (rst),
        .run_toggle (run_toggle),
        .dir        (dir),
        .load       (load),
        .load_val   (load_val),
        .count      (count),
        .running    (running),
        .wrap       (wrap),
        .seg        (seg),
        .cat        (cat)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Active-low glyphs, bit6 = g ... bit0 = a.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- reference model state ----------------
    int                k;          // clock edges since reset release
    int                m_count;
    bit                m_wrap;
    bit                m_running;
    bit                p1, p2, p3; // button level sampled 1, 2, 3 edges ago
    int                m_idx;
    int                m_shadow;
    logic [6:0]        m_seg;
    logic [DIGITS-1:0] m_cat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef MUX_DISPLAY_BCD_EN
    function automatic int to_num(input int v);
        int n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + ((v >> (4 * i)) & 15);
        return n;
    endfunction

    function automatic int from_num(input int n);
        int v = 0;
        for (int i = 0; i < DIGITS; i++) begin
            v = v | ((n % 10) << (4 * i));
            n = n / 10;
        end
        return v;
    endfunction
`endif

    function automatic int load_value(input int v);
        int r = v;
`ifdef MUX_DISPLAY_BCD_EN
        r = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int nib = (v >> (4 * i)) & 15;
            r = r | ((nib > 9 ? 9 : nib) << (4 * i));
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        k = 0; m_count = 0; m_wrap = 0; m_running = 0;
        p1 = 0; p2 = 0; p3 = 0;
        m_idx = 0; m_shadow = 0; m_seg = 7'h7F; m_cat = '1;
    endtask

    task automatic model_edge();
        bit is_tick, is_scan, tog;
        int old_count, modulus, n;
        old_count = m_count;
        is_tick   = (k % TICK_P) == TICK_P - 1;
        is_scan   = (k % SCAN_P) == SCAN_P - 1;
        tog       = p2 && !p3;
        if (load) begin
            m_count = load_value(int'(load_val));
            m_wrap  = 0;
        end else if (is_tick && m_running) begin
`ifdef MUX_DISPLAY_BCD_EN
            modulus = 10 ** DIGITS;
            n       = to_num(m_count);
`else
            modulus = 1 << W;
            n       = m_count;
`endif
            if (dir) begin
                m_wrap = (n == modulus - 1);
                n      = (n + 1) % modulus;
            end else begin
                m_wrap = (n == 0);
                n      = (n + modulus - 1) % modulus;
            end
`ifdef MUX_DISPLAY_BCD_EN
            m_count = from_num(n);
`else
            m_count = n;
`endif
        end else begin
            m_wrap = 0;
        end
        if (tog) m_running = !m_running;
        m_seg = glyph[(m_shadow >> (4 * m_idx)) & 15];
        m_cat = '1;
        m_cat[m_idx] = 1'b0;
        if (is_scan) begin
            m_idx = (m_idx + 1) % DIGITS;
            if (m_idx == 0) m_shadow = old_count;
        end
        p3 = p2; p2 = p1; p1 = run_toggle;
        k++;
    endtask

    task automatic compare_all();
        check("count",   32'(count),   32'(m_count[W-1:0]));
        check("running", 32'(running), 32'(m_running));
        check("wrap",    32'(wrap),    32'(m_wrap));
        check("seg",     32'(seg),     32'(m_seg));
        check("cat",     32'(cat),     32'(m_cat));
    endtask

    // One clock: the model consumes the inputs the DUT sampled on this edge.
    task automatic step();
        @(posedge clk50M);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_seg",     32'(seg),     32'h7F);
        check("rst_cat",     32'(cat),     32'hF);
        check("rst_running", 32'(running), 32'h0);
        check("rst_count",   32'(count),   32'h0);
        check("rst_wrap",    32'(wrap),    32'h0);
        repeat (2) @(posedge clk50M);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic pulse_toggle();
        run_toggle = 1'b1;
        step();
        run_toggle = 1'b0;
        step();
        step();
    endtask

    initial begin
        int n;
        #2;
        do_reset();

        // Start counting up: running rises on the third edge after the press.
        dir = 1'b1;
        pulse_toggle();
        check("run_after_3", 32'(running), 32'h1);
        n = 0;
        while (count === '0 && n < 2 * TICK_P) begin step(); n++; end
        check("first_tick", 32'(count), 32'h1);
        repeat (20) step();

        // Roll-over up, then roll-under down.
        load = 1'b1; load_val = 16'hFFFE;
        step();
        load = 1'b0;
        repeat (20) step();
        dir = 1'b0;
        load = 1'b1; load_val = 16'h0000;
        step();
        load = 1'b0;
        repeat (12) step();

        // Load coinciding with a tick wins.
        while (k % TICK_P != TICK_P - 1) step();
        load = 1'b1; load_val = 16'h1234;
        step();
        load = 1'b0;
        check("load_over_tick", 32'(count), 32'h1234);
        check("load_wrap",      32'(wrap),  32'h0);

        // Stop, reload and watch the display frames.
        pulse_toggle();
        check("stopped", 32'(running), 32'h0);
        load = 1'b1; load_val = 16'h1234;
        step();
        load = 1'b0;
        repeat (12) step();
        n = 0;
        while (cat !== 4'b1110 && n < 8) begin step(); n++; end
        check("digit0_cat", 32'(cat), 32'hE);
        check("digit0_seg", 32'(seg), 32'h19);
        repeat (10) step();

`ifdef MUX_DISPLAY_BCD_EN
        load = 1'b1; load_val = 16'h00AF;
        step();
        load = 1'b0;
        check("bcd_clamp", 32'(count), 32'h0099);
`endif

        // Mid-operation reset, then random traffic with another reset inside.
        pulse_toggle();
        repeat (5) step();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) run_toggle = ~run_toggle;
            if ($urandom_range(0, 31) == 0) dir = ~dir;
            load = ($urandom_range(0, 19) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 7) == 0) load_val = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) load_val = 16'h0000;
            if (i == 400) begin
                load = 1'b0;
                do_reset();
            end
            step();
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
